// File: rtl/twf_stream_gen_if.sv
// Command and twiddle-output stream bundle for twf_stream_gen.
// The DUT takes the slave modport; the command source / pair consumer takes master.
interface twf_stream_gen_if #(
  parameter int IDX_W     = 9,
  parameter int TWF_WIDTH = 9
) ();
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // The source holds valid and its payload stable until that edge; ready may toggle freely.
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [IDX_W-1:0]            cmd_base;
  logic [IDX_W-1:0]            cmd_stride;
  logic [IDX_W:0]              cmd_len;
  logic                        cmd_inv;

  logic                        out_valid;
  logic                        out_ready;
  logic signed [TWF_WIDTH-1:0] twf_re;
  logic signed [TWF_WIDTH-1:0] twf_im;
  logic                        out_last;
  logic                        busy;

  modport master (
    output cmd_valid, cmd_base, cmd_stride, cmd_len, cmd_inv, out_ready,
    input  cmd_ready, out_valid, twf_re, twf_im, out_last, busy
  );

  modport slave (
    input  cmd_valid, cmd_base, cmd_stride, cmd_len, cmd_inv, out_ready,
    output cmd_ready, out_valid, twf_re, twf_im, out_last, busy
  );
endinterface

// File: rtl/twf_stream_gen.sv
// Streaming twiddle generator: one quarter-wave cosine LUT folded into e^(-j2pik/N),
// emitted as one (re, im) pair per cycle through a 3-stage stallable pipeline.
module twf_stream_gen #(
  parameter int N_POINT   = 512,
  parameter int TWF_WIDTH = 9,
  parameter int IDX_W     = $clog2(N_POINT)
) (
  input  logic             clk,
  input  logic             rst,
  twf_stream_gen_if.slave  bus,
  output logic             dbg_state
);
  localparam int QN = N_POINT / 4;
  localparam int S  = 1 << (TWF_WIDTH - 2);
  localparam int RW = IDX_W - 2;

  localparam logic [RW:0]    QN_IDX  = {1'b1, {RW{1'b0}}};
  localparam logic [IDX_W:0] LEN_ONE = {{IDX_W{1'b0}}, 1'b1};

  // Taylor series keeps the table build to plain real arithmetic; no exact .5 ties
  // exist for power-of-two N, so double precision rounds identically to the formula.
  function automatic int cos_q(input int r);
    real x, term, sum;
    x    = 2.0 * 3.14159265358979323846 * real'(r) / real'(N_POINT);
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n < 24; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return $rtoi(sum * real'(S) + 0.5);
  endfunction

  logic signed [TWF_WIDTH-1:0] lut [0:QN];
  for (genvar g = 0; g <= QN; g++) begin : g_lut
    localparam int CV = cos_q(g);
    assign lut[g] = TWF_WIDTH'(CV);
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] stride;
  logic [IDX_W:0]   remaining;
  logic             inv;

  logic             s0_valid, s0_last, s0_inv;
  logic [IDX_W-1:0] s0_k;

  logic                        s1_valid, s1_last, s1_inv;
  logic [1:0]                  s1_q;
  logic signed [TWF_WIDTH-1:0] s1_a, s1_b;

  logic stall, cmd_fire;
  logic [RW:0] idx_a, idx_b;
  logic signed [TWF_WIDTH-1:0] re_n, im_n;

  // Only a held output pair freezes the pipe; an empty S2 lets everything advance.
  assign stall         = bus.out_valid && !bus.out_ready;
  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign bus.busy      = !rst && ((state == RUN) || s0_valid || s1_valid || bus.out_valid);
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      stride    <= '0;
      remaining <= '0;
      inv       <= 1'b0;
      s0_valid  <= 1'b0;
      s0_last   <= 1'b0;
      s0_inv    <= 1'b0;
      s0_k      <= '0;
    end else begin
      if (!stall) s0_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A zero-length command is consumed here and never leaves IDLE.
          if (cmd_fire && (bus.cmd_len != '0)) begin
            state     <= RUN;
            k         <= bus.cmd_base;
            stride    <= bus.cmd_stride;
            remaining <= bus.cmd_len;
            inv       <= bus.cmd_inv;
          end
        end
        RUN: begin
          if (!stall) begin
            s0_valid  <= 1'b1;
            s0_k      <= k;
            s0_last   <= (remaining == LEN_ONE);
            s0_inv    <= inv;
            k         <= k + stride;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign idx_a = {1'b0, s0_k[RW-1:0]};
  assign idx_b = QN_IDX - idx_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_inv   <= 1'b0;
      s1_q     <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (!stall) begin
      s1_valid <= s0_valid;
      s1_last  <= s0_last;
      s1_inv   <= s0_inv;
      s1_q     <= s0_k[IDX_W-1 -: 2];
      s1_a     <= lut[idx_a];
      s1_b     <= lut[idx_b];
    end
  end

  always_comb begin
    re_n = s1_a;
    im_n = -s1_b;
    case (s1_q)
      2'd0: begin re_n = s1_a;  im_n = -s1_b; end
      2'd1: begin re_n = -s1_b; im_n = -s1_a; end
      2'd2: begin re_n = -s1_a; im_n = s1_b;  end
      2'd3: begin re_n = s1_b;  im_n = s1_a;  end
      default: begin re_n = s1_a; im_n = -s1_b; end
    endcase
    if (s1_inv) im_n = -im_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.twf_re    <= '0;
      bus.twf_im    <= '0;
    end else if (!stall) begin
      bus.out_valid <= s1_valid;
      bus.out_last  <= s1_valid && s1_last;
      bus.twf_re    <= re_n;
      bus.twf_im    <= im_n;
    end
  end
endmodule

// File: tb/tb_twf_stream_gen.sv
// Directed bench for twf_stream_gen: main N=512/W=9 instance with an expected-pair
// queue, plus full-range sweeps on N=16/W=16 and N=4096/W=9 instances.
module tb_twf_stream_gen;
  localparam int N  = 512;
  localparam int TW = 9;
  localparam int IW = 9;
  localparam int EW = 2 * TW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  twf_stream_gen_if #(.IDX_W(IW), .TWF_WIDTH(TW)) bus ();
  logic dbg_state;
  twf_stream_gen #(.N_POINT(N), .TWF_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state));

  twf_stream_gen_if #(.IDX_W(4), .TWF_WIDTH(16)) bus_a ();
  logic dbg_a;
  twf_stream_gen #(.N_POINT(16), .TWF_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .dbg_state(dbg_a));

  twf_stream_gen_if #(.IDX_W(12), .TWF_WIDTH(9)) bus_b ();
  logic dbg_b;
  twf_stream_gen #(.N_POINT(4096), .TWF_WIDTH(9)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .dbg_state(dbg_b));

  int checks   = 0;
  int failures = 0;
  int pair_cnt = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  task automatic model(input int n, input int w, input int kk, input bit inv,
                       output int re, output int im);
    real th, s;
    th = 2.0 * 3.141592653589793 * real'(kk) / real'(n);
    s  = real'(1 << (w - 2));
    re = rnd($cos(th) * s);
    im = -rnd($sin(th) * s);
    if (inv) im = -im;
  endtask

  task automatic push_exp(input int re, input int im, input bit last);
    logic [TW-1:0] r, i;
    r = re[TW-1:0];
    i = im[TW-1:0];
    exp_q.push_back({last, r, i});
  endtask

  task automatic push_model(input int base, input int stride, input int len, input bit inv);
    int re, im;
    for (int i = 0; i < len; i++) begin
      model(N, TW, (base + i * stride) % N, inv, re, im);
      push_exp(re, im, i == len - 1);
    end
  endtask

  task automatic send_cmd(input int base, input int stride, input int len, input bit inv);
    int t;
    t = 0;
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_base   = IW'(base);
    bus.cmd_stride = IW'(stride);
    bus.cmd_len    = (IW + 1)'(len);
    bus.cmd_inv    = inv;
    @(negedge clk);
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_accept", int'(bus.cmd_ready), 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input bit rand_ready);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.busy) && t < 3000) begin
      @(posedge clk); #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      t++;
    end
    bus.out_ready = 1'b1;
    chk("drain_in_time", int'(t < 3000), 1);
  endtask

  // Scoreboard: pops one expected pair per handshake and checks that stalled outputs hold.
  logic [EW:0] prev_out;
  logic [EW:0] now_out;
  logic [EW-1:0] e;
  bit prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      now_out = {bus.out_valid, bus.out_last, bus.twf_re, bus.twf_im};
      if (prev_stall) chk("stall_hold", now_out, prev_out);
      if (bus.out_valid && bus.out_ready) begin
        chk("pair_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("twf_re", $signed(bus.twf_re), $signed(e[2*TW-1:TW]));
          chk("twf_im", $signed(bus.twf_im), $signed(e[TW-1:0]));
          chk("out_last", int'(bus.out_last), int'(e[EW-1]));
        end
        pair_cnt++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = now_out;
    end
  end

  initial begin
    int re, im, kk, t, p0;
    int ks[5];
    int exp_re[5];
    int exp_im[5];
    ks     = '{0, 64, 128, 256, 384};
    exp_re = '{128, 91, 0, -128, 0};
    exp_im = '{0, -91, -128, 0, 128};

    bus.cmd_valid = 1'b0; bus.cmd_base = '0; bus.cmd_stride = '0; bus.cmd_len = '0;
    bus.cmd_inv = 1'b0; bus.out_ready = 1'b1;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_base = '0; bus_a.cmd_stride = '0; bus_a.cmd_len = '0;
    bus_a.cmd_inv = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_base = '0; bus_b.cmd_stride = '0; bus_b.cmd_len = '0;
    bus_b.cmd_inv = 1'b0; bus_b.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_twf_re", $signed(bus.twf_re), 0);
    chk("rst_twf_im", $signed(bus.twf_im), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 0);
    chk("rst_state", int'(dbg_state), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", int'(bus.cmd_ready), 1);

    // Single twiddles at quadrant points, each 3 cycles after accept
    for (int i = 0; i < 5; i++) begin
      push_exp(exp_re[i], exp_im[i], 1'b1);
      send_cmd(ks[i], 0, 1, 1'b0);
      for (int c = 0; c <= 3; c++) begin
        @(negedge clk);
        chk("latency_valid", int'(bus.out_valid), int'(c == 3));
      end
      drain(1'b0);
    end

    // Exponent wrap, forward then inverse
    push_exp(128, 3, 1'b0); push_exp(128, -3, 1'b0); push_exp(128, -9, 1'b1);
    send_cmd(510, 4, 3, 1'b0);
    drain(1'b0);
    push_exp(128, -3, 1'b0); push_exp(128, 3, 1'b0); push_exp(128, 9, 1'b1);
    send_cmd(510, 4, 3, 1'b1);
    drain(1'b0);

    // Random backpressure
    p0 = pair_cnt;
    push_model(7, 33, 8, 1'b1);
    send_cmd(7, 33, 8, 1'b1);
    drain(1'b1);
    chk("bp_pair_count", pair_cnt - p0, 8);

    // Zero-length command, then a full-length stride-1 burst
    send_cmd(5, 1, 0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("len0_quiet", int'(bus.out_valid | bus.busy), 0);
    end
    p0 = pair_cnt;
    push_model(0, 1, N, 1'b0);
    send_cmd(0, 1, N, 1'b0);
    drain(1'b0);
    chk("full_pair_count", pair_cnt - p0, N);
    chk("full_busy_low", int'(bus.busy), 0);

    // Reset after three of ten pairs
    p0 = pair_cnt;
    push_model(100, 3, 10, 1'b0);
    send_cmd(100, 3, 10, 1'b0);
    t = 0;
    while (pair_cnt - p0 < 3 && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    chk("rst_mid_reached", pair_cnt - p0, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", int'(bus.out_valid), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    p0 = pair_cnt;
    repeat (15) @(negedge clk);
    chk("no_pairs_after_rst", pair_cnt - p0, 0);
    push_model(200, 5, 4, 1'b0);
    send_cmd(200, 5, 4, 1'b0);
    drain(1'b0);
    chk("post_rst_pairs", pair_cnt - p0, 4);

    // Sweep N=16, W=16
    @(posedge clk); #1;
    bus_a.cmd_valid = 1'b1; bus_a.cmd_base = '0; bus_a.cmd_stride = 4'd1;
    bus_a.cmd_len = 5'd16; bus_a.cmd_inv = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus_a.cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    bus_a.cmd_valid = 1'b0;
    kk = 0; t = 0;
    while (kk < 16 && t < 200) begin
      @(negedge clk);
      t++;
      if (bus_a.out_valid) begin
        model(16, 16, kk, 1'b0, re, im);
        chk("sweep16_re", $signed(bus_a.twf_re), re);
        chk("sweep16_im", $signed(bus_a.twf_im), im);
        kk++;
      end
    end
    chk("sweep16_count", kk, 16);

    // Sweep N=4096, W=9, inverse
    @(posedge clk); #1;
    bus_b.cmd_valid = 1'b1; bus_b.cmd_base = '0; bus_b.cmd_stride = 12'd1;
    bus_b.cmd_len = 13'd4096; bus_b.cmd_inv = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus_b.cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    bus_b.cmd_valid = 1'b0;
    kk = 0; t = 0;
    while (kk < 4096 && t < 5000) begin
      @(negedge clk);
      t++;
      if (bus_b.out_valid) begin
        model(4096, 9, kk, 1'b1, re, im);
        chk("sweep4k_re", $signed(bus_b.twf_re), re);
        chk("sweep4k_im", $signed(bus_b.twf_im), im);
        kk++;
      end
    end
    chk("sweep4k_count", kk, 4096);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
